// File: rtl/alu_matrix_operand_loader_pkg.sv
// alu_matrix_pkg: shared definitions for the matrix operand loader.
//   DIM    - maximum matrix dimension (5)
//   W      - element width in bits (8)
//   FLAT_W - width of one flat operand bus (DIM*DIM*W)
//   state_t - loader FSM encoding (IDLE, LOAD_A, LOAD_B, HOLD)
//   elem_lsb(i,j) - bit offset of element (i,j) inside a flat bus
package alu_matrix_pkg;
    localparam int DIM    = 5;
    localparam int W      = 8;
    localparam int FLAT_W = DIM * DIM * W;
    localparam int IDX_W  = $clog2(FLAT_W);
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] elem_lsb(input logic [CNT_W-1:0] i,
                                                  input logic [CNT_W-1:0] j);
        return IDX_W'((int'(i) * DIM + int'(j)) * W);
    endfunction
endpackage

// File: rtl/alu_matrix_operand_loader_if.sv
// alu_matrix_operand_loader_if: byte stream in, flat operands out.
//   in_data/in_valid/in_ready : element stream. A beat happens on a cycle where
//       in_valid && in_ready; in_ready depends only on loader state, never on
//       in_valid, and in_data must be stable while in_valid is high.
//   a_flat/b_flat/op_valid/op_ack : operand hand-off. While op_valid is high the
//       buses are constant; a one-cycle op_ack releases them.
//   modport master : producer/consumer side (drives stream, ack)
//   modport slave  : loader side
interface alu_matrix_operand_loader_if;
    import alu_matrix_pkg::*;

    logic [W-1:0]      in_data;
    logic              in_valid;
    logic              in_ready;
    logic [FLAT_W-1:0] a_flat;
    logic [FLAT_W-1:0] b_flat;
    logic              op_valid;
    logic              op_ack;

    modport master (
        output in_data, in_valid, op_ack,
        input  in_ready, a_flat, b_flat, op_valid
    );

    modport slave (
        input  in_data, in_valid, op_ack,
        output in_ready, a_flat, b_flat, op_valid
    );
endinterface

// File: rtl/alu_matrix_operand_loader_index_counter.sv
// matrix_index_counter: row/col position within an N x N matrix.
//   clk, rst   : clock, synchronous active-high reset
//   i_clear    : return to (0,0)
//   i_step     : advance one element
//   i_swap     : 0 = column-fastest (row-major), 1 = row-fastest (column-major)
//   i_n_lat    : active dimension N (1..DIM)
//   o_row/o_col: current position
//   o_last     : current position is (N-1,N-1); stepping here wraps to (0,0)
module matrix_index_counter
    import alu_matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic             i_swap,
    input  logic [CNT_W-1:0] i_n_lat,
    output logic [CNT_W-1:0] o_row,
    output logic [CNT_W-1:0] o_col,
    output logic             o_last
);
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] w_max;
    logic             w_row_end;
    logic             w_col_end;

    assign w_max     = i_n_lat - CNT_W'(1);
    assign w_row_end = (r_row == w_max);
    assign w_col_end = (r_col == w_max);
    assign o_last    = w_row_end && w_col_end;
    assign o_row     = r_row;
    assign o_col     = r_col;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_step) begin
            if (o_last) begin
                // Wrap so the next matrix starts at (0,0) without a bubble.
                r_row <= '0;
                r_col <= '0;
            end else if (i_swap) begin
                if (w_row_end) begin
                    r_row <= '0;
                    r_col <= r_col + CNT_W'(1);
                end else begin
                    r_row <= r_row + CNT_W'(1);
                end
            end else begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= r_row + CNT_W'(1);
                end else begin
                    r_col <= r_col + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/alu_matrix_operand_loader.sv
// alu_matrix_operand_loader: packs a byte-serial stream (A then B, N*N each)
// into two flat DIM x DIM operand buses, zero-padded outside N x N, and holds
// them under op_valid until op_ack.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load command, honoured only in IDLE
//   size      : N, sampled on accepted start; 0 or >DIM loads DIM and flags size_err
//   busy      : loader not idle
//   size_err  : one-cycle pulse after a start with an illegal size
//   dbg_state : current FSM state
//   bus       : stream + operand interface (slave modport)
// Build option: MATRIX_LOADER_TRANSPOSE_B_EN makes the B stream column-major.
module alu_matrix_operand_loader
    import alu_matrix_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [2:0]                   size,
    output logic                         busy,
    output logic                         size_err,
    output state_t                       dbg_state,
    alu_matrix_operand_loader_if.slave   bus
);
    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_n_lat;
    logic [FLAT_W-1:0] r_a_flat;
    logic [FLAT_W-1:0] r_b_flat;
    logic              r_size_err;

    logic              w_in_ready;
    logic              w_beat;
    logic              w_start_ok;
    logic              w_size_bad;
    logic              w_swap;
    logic [CNT_W-1:0]  w_row;
    logic [CNT_W-1:0]  w_col;
    logic              w_last;
    logic [IDX_W-1:0]  w_lsb;

    assign w_in_ready = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    assign w_beat     = bus.in_valid && w_in_ready;
    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_size_bad = (size == 3'd0) || (size > 3'(DIM));
    assign w_lsb      = elem_lsb(w_row, w_col);

`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
    assign w_swap = (r_state == ST_LOAD_B);
`else
    assign w_swap = 1'b0;
`endif

    matrix_index_counter u_idx (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start_ok),
        .i_step  (w_beat),
        .i_swap  (w_swap),
        .i_n_lat (r_n_lat),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_last  (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start)            w_state_next = ST_LOAD_A;
            ST_LOAD_A: if (w_beat && w_last) w_state_next = ST_LOAD_B;
            ST_LOAD_B: if (w_beat && w_last) w_state_next = ST_HOLD;
            // A start coinciding with op_ack is dropped: IDLE only listens
            // to start once it has been entered.
            ST_HOLD:   if (bus.op_ack)       w_state_next = ST_IDLE;
            default:                         w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_n_lat    <= CNT_W'(DIM);
            r_a_flat   <= '0;
            r_b_flat   <= '0;
            r_size_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_size_err <= w_start_ok && w_size_bad;
            if (w_start_ok) begin
                r_a_flat <= '0;
                r_b_flat <= '0;
                r_n_lat  <= w_size_bad ? CNT_W'(DIM) : size;
            end
            if (w_beat && (r_state == ST_LOAD_A)) begin
                r_a_flat[w_lsb +: W] <= bus.in_data;
            end
            if (w_beat && (r_state == ST_LOAD_B)) begin
                r_b_flat[w_lsb +: W] <= bus.in_data;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.a_flat   = r_a_flat;
    assign bus.b_flat   = r_b_flat;
    assign bus.op_valid = (r_state == ST_HOLD);
    assign busy         = (r_state != ST_IDLE);
    assign size_err     = r_size_err;
    assign dbg_state    = r_state;
endmodule
